util_delay_arbiter: RTL

Two-requester round-robin arbiter and sequencer for one shared fixed-latency pipelined unit, such as a `DELAY`-stage delay-array datapath. It issues at most one operation per cycle into the unit and tracks each in-flight operation's owner with an internal tag pipeline. It steers each result into a per-requester response FIFO and uses credits so results are never dropped. It sits between the pipeline stages that request the shared unit and the unit itself.

---
 rtl/util_delay_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/util_delay_arbiter.sv
// util_delay_arbiter
//
// Two-requester round-robin arbiter and sequencer for one shared,
// fixed-latency, pipelined unit. At most one operation is issued per cycle.
// A tag pipeline of DELAY stages remembers who owns each in-flight
// operation, so that each result can be steered into that requester's
// response FIFO. Credits (in-flight + buffered <= DEPTH) guarantee that a
// result always finds room in its FIFO when it comes out of the unit.
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous, active-low reset
//   flush      synchronous kill of all in-flight and buffered work
//   req_valid  per-requester request valid (bit i = requester i)
//   req_data   per-requester operand, requester i at [i*WIDTH +: WIDTH]
//   req_ready  per-requester grant (one-hot or zero)
//   unit_valid operation issued to the shared unit this cycle
//   unit_id    owner of the issued operation
//   unit_in    operand driven to the shared unit
//   unit_out   unit result, valid exactly DELAY cycles after unit_in
//   rsp_valid  response FIFO i is non-empty
//   rsp_data   head of response FIFO i at [i*WIDTH +: WIDTH]
//   rsp_ready  pop response FIFO i

module util_delay_arbiter #(
  parameter int WIDTH = 32,
  parameter int DELAY = 4,
  parameter int DEPTH = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic [1:0]         req_valid,
  input  logic [2*WIDTH-1:0] req_data,
  output logic [1:0]         req_ready,
  output logic               unit_valid,
  output logic               unit_id,
  output logic [WIDTH-1:0]   unit_in,
  input  logic [WIDTH-1:0]   unit_out,
  output logic [1:0]         rsp_valid,
  output logic [2*WIDTH-1:0] rsp_data,
  input  logic [1:0]         rsp_ready
);

  localparam int CW  = $clog2(DEPTH + 1);
  localparam int CW1 = CW + 1;
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [AW-1:0]  LAST_SLOT    = AW'(DEPTH - 1);
  localparam logic [CW1-1:0] CREDIT_LIMIT = CW1'(DEPTH);

  // Per-requester bookkeeping.
  logic [CW-1:0]    inflight [2];
  logic [CW-1:0]    count    [2];
  logic [AW-1:0]    wr_ptr   [2];
  logic [AW-1:0]    rd_ptr   [2];
  logic [WIDTH-1:0] fifo_mem [2][DEPTH];

  // Ownership tags travelling alongside the operations inside the unit.
  logic [DELAY-1:0] tag_valid;
  logic [DELAY-1:0] tag_id;

  // Round-robin pointer: the requester that wins a tie.
  logic rr;

  logic [1:0] eligible;
  logic [1:0] grant_vec;
  logic [1:0] push_vec;
  logic [1:0] pop_vec;
  logic       any_grant;
  logic       winner;
  logic       retire;

  function automatic logic [AW-1:0] next_slot(input logic [AW-1:0] slot);
    return (slot == LAST_SLOT) ? '0 : slot + AW'(1);
  endfunction

  // Credit check. Only registered counters are used, so a pop in this cycle
  // frees its credit one cycle later. Reset and flush suppress all grants.
  always_comb begin
    eligible = 2'b00;
    for (int i = 0; i < 2; i++) begin
      eligible[i] = reset && !flush && req_valid[i] &&
                    (({1'b0, inflight[i]} + {1'b0, count[i]}) < CREDIT_LIMIT);
    end
  end

  // Arbitration and combinational issue into the shared unit.
  always_comb begin
    any_grant = |eligible;
    winner    = 1'b0;
    if (&eligible) begin
      winner = rr;
    end else if (eligible[1]) begin
      winner = 1'b1;
    end
    grant_vec = 2'b00;
    if (any_grant) begin
      grant_vec[winner] = 1'b1;
    end
    req_ready  = grant_vec;
    unit_valid = any_grant;
    unit_id    = any_grant ? winner : 1'b0;
    unit_in    = '0;
    if (any_grant) begin
      unit_in = winner ? req_data[2*WIDTH-1:WIDTH] : req_data[WIDTH-1:0];
    end
  end

  // Retire path: the oldest tag says whose result is on unit_out right now.
  // A result landing during a flush is dropped.
  always_comb begin
    retire   = tag_valid[DELAY-1] && !flush;
    push_vec = {retire && tag_id[DELAY-1], retire && !tag_id[DELAY-1]};
  end

  // Response side: FIFO heads and pops. Pops are ignored during a flush
  // because rsp_valid is forced low then.
  always_comb begin
    rsp_valid = 2'b00;
    pop_vec   = 2'b00;
    rsp_data  = '0;
    for (int i = 0; i < 2; i++) begin
      rsp_valid[i] = reset && !flush && (count[i] != '0);
      pop_vec[i]   = rsp_valid[i] && rsp_ready[i];
      rsp_data[i*WIDTH +: WIDTH] = fifo_mem[i][rd_ptr[i]];
    end
  end

  // Tag pipeline: shifts every cycle, stage 0 captures the current issue.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tag_valid <= '0;
      tag_id    <= '0;
    end else if (flush) begin
      tag_valid <= '0;
      tag_id    <= '0;
    end else begin
      tag_valid[0] <= unit_valid;
      tag_id[0]    <= unit_id;
      for (int k = 1; k < DELAY; k++) begin
        tag_valid[k] <= tag_valid[k-1];
        tag_id[k]    <= tag_id[k-1];
      end
    end
  end

  // Round-robin pointer: after a grant the other requester gets priority.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr <= 1'b0;
    end else if (flush) begin
      rr <= 1'b0;
    end else if (any_grant) begin
      rr <= ~winner;
    end
  end

  // Credit counters and response FIFOs. Grant and retire on the same
  // requester cancel in inflight; push and pop on the same FIFO cancel in
  // count, and the write goes to the slot being vacated when the FIFO is
  // full, which is safe because the head is read before the edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        inflight[i] <= '0;
        count[i]    <= '0;
        wr_ptr[i]   <= '0;
        rd_ptr[i]   <= '0;
        for (int j = 0; j < DEPTH; j++) begin
          fifo_mem[i][j] <= '0;
        end
      end
    end else if (flush) begin
      for (int i = 0; i < 2; i++) begin
        inflight[i] <= '0;
        count[i]    <= '0;
        wr_ptr[i]   <= '0;
        rd_ptr[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        inflight[i] <= inflight[i] + CW'(grant_vec[i]) - CW'(push_vec[i]);
        count[i]    <= count[i] + CW'(push_vec[i]) - CW'(pop_vec[i]);
        if (push_vec[i]) begin
          fifo_mem[i][wr_ptr[i]] <= unit_out;
          wr_ptr[i]              <= next_slot(wr_ptr[i]);
        end
        if (pop_vec[i]) begin
          rd_ptr[i] <= next_slot(rd_ptr[i]);
        end
      end
    end
  end

endmodule
